// File: rtl/tjrpu_pkg.sv
// ---------------------------------------------------------------------------
// tjrpu_pkg
// Shared definitions for the tjrpu scratch-SRAM arbiter:
//   - arb_state_t : sequencer states (IDLE -> ISSUE -> WAIT -> RESP)
//   - owner_t     : requester encoding (HOST=0, CORE=1); also the bit index
//                   of each requester in the picker's req vector
//   - TJRPU_BASE_ADDR : default Wishbone byte base of the SRAM window
// ---------------------------------------------------------------------------
package tjrpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_CORE = 1'b1
    } owner_t;

    localparam logic [31:0] TJRPU_BASE_ADDR = 32'h3000_0000;

endpackage

// File: rtl/tjrpu_rr_arb2.sv
// ---------------------------------------------------------------------------
// tjrpu_rr_arb2
// Two-input picker for the scratch-SRAM arbiter. Purely combinational.
//   req    in  2  request vector, indexed by owner_t (bit0 host, bit1 core)
//   last   in  1  owner granted most recently
//   winner out 1  selected owner (meaningful only when valid)
//   valid  out 1  at least one request present
// Configuration macro: TJRPU_ARB_HOST_PRIO_EN
//   undefined : round-robin, a tie goes to the requester that is not `last`
//   defined   : fixed priority, a tie always goes to the host (`last` ignored)
// ---------------------------------------------------------------------------
module tjrpu_rr_arb2
    import tjrpu_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output owner_t     winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = OWN_HOST;
        if (req == 2'b10) begin
            winner = OWN_CORE;
        end else if (req == 2'b11) begin
`ifdef TJRPU_ARB_HOST_PRIO_EN
            winner = OWN_HOST;
`else
            if (last == OWN_HOST) winner = OWN_CORE;
            else                  winner = OWN_HOST;
`endif
        end
    end

`ifdef TJRPU_ARB_HOST_PRIO_EN
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/tjrpu_mem_arb.sv
// ---------------------------------------------------------------------------
// tjrpu_mem_arb
// Shares one single-port 32-bit scratch SRAM between the Caravel Wishbone
// host and the RPU core data port. Every access runs a fixed 4-cycle
// sequence IDLE -> ISSUE -> WAIT -> RESP; all outputs are flop outputs.
//
// Ports
//   wb_clk_i / wb_rst_i        clock, asynchronous active-high reset
//   wbs_cyc_i .. wbs_dat_i     Wishbone slave request (byte address)
//   wbs_ack_o, wbs_dat_o       Wishbone ack pulse and read data
//   core_req_i .. core_dat_i   core request (word address), held until gnt
//   core_gnt_o                 core request accepted (pulse, ISSUE cycle)
//   core_rvalid_o, core_dat_o  core response pulse and read data
//   mem_csb_o .. mem_din_o     OpenRAM-style macro port (active-low csb/web)
//   mem_dout_i                 SRAM read data, valid the cycle after csb low
//
// Parameters
//   AW         SRAM word-address width (depth 2**AW)
//   BASE_ADDR  Wishbone byte base of the SRAM window
//
// Configuration macro: TJRPU_ARB_HOST_PRIO_EN (host wins ties; see
// tjrpu_rr_arb2). Default build is round-robin.
// ---------------------------------------------------------------------------
module tjrpu_mem_arb
    import tjrpu_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter logic [31:0] BASE_ADDR = TJRPU_BASE_ADDR
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [3:0]    core_sel_i,
    input  logic [AW-1:0] core_adr_i,
    input  logic [31:0]   core_dat_i,
    output logic          core_gnt_o,
    output logic          core_rvalid_o,
    output logic [31:0]   core_dat_o,
    output logic          mem_csb_o,
    output logic          mem_web_o,
    output logic [3:0]    mem_wmask_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_din_o,
    input  logic [31:0]   mem_dout_i
);

    arb_state_t    state_q, state_d;
    owner_t        last_q, last_d, owner_q, owner_d;
    logic          we_q, we_d, hit_q, hit_d, abort_q, abort_d;
    logic          csb_q, csb_d, web_q, web_d;
    logic [3:0]    wmask_q, wmask_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   din_q, din_d;
    logic          ack_q, ack_d, gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic [31:0]   wbs_dat_q, wbs_dat_d, core_dat_q, core_dat_d;

    owner_t        arb_winner;
    logic          arb_valid;
    logic          host_req, host_hit;
    logic          pick_we, pick_hit;
    logic [3:0]    pick_sel;
    logic [AW-1:0] pick_addr;
    logic [31:0]   pick_din;
    logic [31:0]   rdata;

    // Byte offset inside a word is irrelevant for 32-bit accesses.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    assign host_req = wbs_cyc_i & wbs_stb_i;
    // Window compare only; the word index below it wraps modulo 2**AW.
    assign host_hit = (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);

    tjrpu_rr_arb2 u_pick (
        .req    ({core_req_i, host_req}),
        .last   (last_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Fields of whichever requester won this cycle's arbitration.
    always_comb begin
        if (arb_winner == OWN_HOST) begin
            pick_we   = wbs_we_i;
            pick_sel  = wbs_sel_i;
            pick_addr = wbs_adr_i[AW+1:2];
            pick_din  = wbs_dat_i;
            pick_hit  = host_hit;
        end else begin
            pick_we   = core_we_i;
            pick_sel  = core_sel_i;
            pick_addr = core_adr_i;
            pick_din  = core_dat_i;
            pick_hit  = 1'b1;
        end
    end

    // Writes and host misses return zero regardless of what the macro drives.
    assign rdata = (we_q || !hit_q) ? 32'h0 : mem_dout_i;

    always_comb begin
        // NOTE: every signal gets a default first so no latch can be inferred.
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        we_d       = we_q;
        hit_d      = hit_q;
        abort_d    = abort_q;
        csb_d      = 1'b1;
        web_d      = 1'b1;
        wmask_d    = wmask_q;
        addr_d     = addr_q;
        din_d      = din_q;
        ack_d      = 1'b0;
        gnt_d      = 1'b0;
        rvalid_d   = 1'b0;
        wbs_dat_d  = wbs_dat_q;
        core_dat_d = core_dat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_winner;
                    last_d  = arb_winner;
                    we_d    = pick_we;
                    hit_d   = pick_hit;
                    abort_d = 1'b0;
                    addr_d  = pick_addr;
                    din_d   = pick_din;
                    wmask_d = pick_we ? pick_sel : 4'h0;
                    // Macro strobe is registered here so it is live in ISSUE.
                    csb_d   = ~pick_hit;
                    web_d   = ~pick_we;
                    gnt_d   = (arb_winner == OWN_CORE);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (owner_q == OWN_HOST && !wbs_cyc_i) abort_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // cyc is checked once more here so a drop in WAIT also aborts.
                if (owner_q == OWN_HOST) begin
                    if (!abort_q && wbs_cyc_i) begin
                        ack_d     = 1'b1;
                        wbs_dat_d = rdata;
                    end
                end else begin
                    rvalid_d   = 1'b1;
                    core_dat_d = rdata;
                end
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            last_q     <= OWN_CORE;
            owner_q    <= OWN_HOST;
            we_q       <= 1'b0;
            hit_q      <= 1'b0;
            abort_q    <= 1'b0;
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            wmask_q    <= 4'h0;
            addr_q     <= '0;
            din_q      <= 32'h0;
            ack_q      <= 1'b0;
            gnt_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            wbs_dat_q  <= 32'h0;
            core_dat_q <= 32'h0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            hit_q      <= hit_d;
            abort_q    <= abort_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            wmask_q    <= wmask_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            ack_q      <= ack_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            wbs_dat_q  <= wbs_dat_d;
            core_dat_q <= core_dat_d;
        end
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = wbs_dat_q;
    assign core_gnt_o    = gnt_q;
    assign core_rvalid_o = rvalid_q;
    assign core_dat_o    = core_dat_q;
    assign mem_csb_o     = csb_q;
    assign mem_web_o     = web_q;
    assign mem_wmask_o   = wmask_q;
    assign mem_addr_o    = addr_q;
    assign mem_din_o     = din_q;

endmodule

// File: tb/tb_tjrpu_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_tjrpu_mem_arb
// Self-checking bench for tjrpu_mem_arb. A behavioural model predicts, per
// round of requests, the service order, the cycle of every gnt/strobe/ack/
// rvalid and the returned data, using a plain word array as the memory.
// An SRAM macro model provides mem_dout_i. Honours TJRPU_ARB_HOST_PRIO_EN.
// ---------------------------------------------------------------------------
module tb_tjrpu_mem_arb;
    import tjrpu_pkg::*;

    localparam int          AW    = 8;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i, wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          core_req_i, core_we_i;
    logic [3:0]    core_sel_i;
    logic [AW-1:0] core_adr_i;
    logic [31:0]   core_dat_i;
    logic          core_gnt_o, core_rvalid_o;
    logic [31:0]   core_dat_o;
    logic          mem_csb_o, mem_web_o;
    logic [3:0]    mem_wmask_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_din_o;
    logic [31:0]   mem_dout_i;

    always #5 wb_clk_i = ~wb_clk_i;

    tjrpu_mem_arb #(.AW(AW), .BASE_ADDR(BASE)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .core_req_i    (core_req_i),
        .core_we_i     (core_we_i),
        .core_sel_i    (core_sel_i),
        .core_adr_i    (core_adr_i),
        .core_dat_i    (core_dat_i),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_dat_o    (core_dat_o),
        .mem_csb_o     (mem_csb_o),
        .mem_web_o     (mem_web_o),
        .mem_wmask_o   (mem_wmask_o),
        .mem_addr_o    (mem_addr_o),
        .mem_din_o     (mem_din_o),
        .mem_dout_i    (mem_dout_i)
    );

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM macro: one-cycle read latency; write cycles leave junk on dout.
    logic [31:0] sram [DEPTH];
    always @(posedge wb_clk_i) begin
        if (!mem_csb_o) begin
            if (!mem_web_o) begin
                sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_din_o, mem_wmask_o);
                mem_dout_i       <= $urandom;
            end else begin
                mem_dout_i <= sram[mem_addr_o];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          valid;
        bit          is_core;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] adr;     // host: byte address, core: word address
        logic [31:0] dat;
        bit          abort;   // host drops cyc in WAIT
    } op_t;

    typedef struct {
        op_t           op;
        bit            hit;
        logic [AW-1:0] word;
        logic [31:0]   rdata;
    } slot_t;

    logic [31:0] ref_mem [DEPTH];
    bit          last_core;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(bit is_core, bit we, logic [3:0] sel, logic [31:0] adr,
                               logic [31:0] dat, bit abort);
        op_t o;
        o.valid = 1'b1; o.is_core = is_core; o.we = we; o.sel = sel;
        o.adr = adr; o.dat = dat; o.abort = abort;
        return o;
    endfunction

    function automatic op_t none();
        op_t o;
        o = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        o.valid = 1'b0;
        return o;
    endfunction

    function automatic op_t rand_host();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 6) != 0) a = {BASE[31:AW+2], a[AW+1:0]};
        else if (a[31:AW+2] == BASE[31:AW+2]) a[31] = ~a[31];
        return mk(1'b0, 1'($urandom), 4'($urandom), a, $urandom, $urandom_range(0, 9) == 0);
    endfunction

    function automatic op_t rand_core();
        return mk(1'b1, 1'($urandom), 4'($urandom), 32'($urandom_range(0, DEPTH - 1)),
                  $urandom, 1'b0);
    endfunction

    task automatic drop_host();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        wbs_adr_i = $urandom; wbs_dat_i = $urandom;
    endtask

    task automatic drop_core();
        core_req_i = 1'b0;
        core_adr_i = AW'($urandom); core_dat_i = $urandom; core_we_i = 1'($urandom);
    endtask

    // One round: requests appear together while the arbiter is idle; each
    // requester is served in one 4-cycle slot in model-predicted order.
    task automatic run_round(input op_t h, input op_t c);
        op_t   order[$];
        slot_t slots[$];
        bit    host_first;
        int    n;
        if (h.valid && c.valid) begin
`ifdef TJRPU_ARB_HOST_PRIO_EN
            host_first = 1'b1;
`else
            host_first = last_core;
`endif
            if (host_first) begin order.push_back(h); order.push_back(c); end
            else            begin order.push_back(c); order.push_back(h); end
        end else if (h.valid) order.push_back(h);
        else if (c.valid)     order.push_back(c);

        foreach (order[i]) begin
            slot_t s;
            s.op      = order[i];
            last_core = s.op.is_core;
            s.hit     = s.op.is_core || (s.op.adr[31:AW+2] == BASE[31:AW+2]);
            s.word    = s.op.is_core ? s.op.adr[AW-1:0] : s.op.adr[AW+1:2];
            s.rdata   = (!s.op.we && s.hit) ? ref_mem[s.word] : 32'h0;
            if (s.op.we && s.hit) ref_mem[s.word] = merge(ref_mem[s.word], s.op.dat, s.op.sel);
            slots.push_back(s);
        end
        n = slots.size();

        @(posedge wb_clk_i); #1;
        if (h.valid) begin
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = h.we;
            wbs_sel_i = h.sel; wbs_adr_i = h.adr; wbs_dat_i = h.dat;
        end
        if (c.valid) begin
            core_req_i = 1'b1; core_we_i = c.we; core_sel_i = c.sel;
            core_adr_i = c.adr[AW-1:0]; core_dat_i = c.dat;
        end

        for (int cyc = 1; cyc <= 4 * n; cyc++) begin
            logic exp_ack, exp_gnt, exp_rv, exp_csb;
            exp_ack = 1'b0; exp_gnt = 1'b0; exp_rv = 1'b0; exp_csb = 1'b1;
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            for (int s = 0; s < n; s++) begin
                if (cyc == 4 * s + 1) begin
                    exp_csb = !slots[s].hit;
                    exp_gnt = slots[s].op.is_core;
                    if (slots[s].hit) begin
                        check("mem_addr", 32'(mem_addr_o), 32'(slots[s].word));
                        check("mem_web", 32'(mem_web_o), 32'(!slots[s].op.we));
                        check("mem_wmask", 32'(mem_wmask_o),
                              32'(slots[s].op.we ? slots[s].op.sel : 4'h0));
                        if (slots[s].op.we) check("mem_din", mem_din_o, slots[s].op.dat);
                    end
                end
                if (cyc == 4 * s + 3) begin
                    if (slots[s].op.is_core) begin
                        exp_rv = 1'b1;
                        check("core_dat", core_dat_o, slots[s].rdata);
                    end else if (!slots[s].op.abort) begin
                        exp_ack = 1'b1;
                        check("wbs_dat", wbs_dat_o, slots[s].rdata);
                    end
                end
            end
            check("wbs_ack", 32'(wbs_ack_o), 32'(exp_ack));
            check("core_gnt", 32'(core_gnt_o), 32'(exp_gnt));
            check("core_rvalid", 32'(core_rvalid_o), 32'(exp_rv));
            check("mem_csb", 32'(mem_csb_o), 32'(exp_csb));
            for (int s = 0; s < n; s++) begin
                if (!slots[s].op.is_core && cyc == 4 * s + (slots[s].op.abort ? 2 : 3)) drop_host();
                if (slots[s].op.is_core && cyc == 4 * s + 1) drop_core();
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csb"},      32'(mem_csb_o), 32'h1);
        check({tag, "_web"},      32'(mem_web_o), 32'h1);
        check({tag, "_wmask"},    32'(mem_wmask_o), 32'h0);
        check({tag, "_addr"},     32'(mem_addr_o), 32'h0);
        check({tag, "_din"},      mem_din_o, 32'h0);
        check({tag, "_ack"},      32'(wbs_ack_o), 32'h0);
        check({tag, "_gnt"},      32'(core_gnt_o), 32'h0);
        check({tag, "_rvalid"},   32'(core_rvalid_o), 32'h0);
        check({tag, "_wbs_dat"},  wbs_dat_o, 32'h0);
        check({tag, "_core_dat"}, core_dat_o, 32'h0);
    endtask

    // Core read interrupted by reset during WAIT: no response may follow.
    task automatic reset_mid_core_read(input logic [AW-1:0] word);
        @(posedge wb_clk_i); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_sel_i = 4'hF; core_adr_i = word;
        @(posedge wb_clk_i); @(negedge wb_clk_i);
        check("rst_seq_gnt", 32'(core_gnt_o), 32'h1);
        drop_core();
        @(posedge wb_clk_i); #2;
        wb_rst_i = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge wb_clk_i); @(negedge wb_clk_i);
        wb_rst_i  = 1'b0;
        last_core = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge wb_clk_i); @(negedge wb_clk_i);
            check("post_rst_rvalid", 32'(core_rvalid_o), 32'h0);
            check("post_rst_csb", 32'(mem_csb_o), 32'h1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        core_req_i = 1'b0; core_we_i = 1'b0; core_sel_i = 4'h0;
        core_adr_i = '0; core_dat_i = 32'h0;
        last_core = 1'b1;
        @(posedge wb_clk_i); #1;
        check_reset_outputs("rst_init");
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Simultaneous requests from reset: H,C then H,C again (writes only,
        // memory contents are still unknown).
        for (int i = 0; i < 4; i++)
            run_round(mk(1'b0, 1'b1, 4'hF, BASE + 32'(4 * (i + 1)), $urandom, 1'b0),
                      mk(1'b1, 1'b1, 4'hF, 32'(i + 8), $urandom, 1'b0));

        // Fill every word so later reads have defined contents.
        for (int w = 0; w < DEPTH; w++)
            run_round(mk(1'b0, 1'b1, 4'hF, BASE + 32'(4 * w), $urandom, 1'b0), none());

        run_round(mk(1'b0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0), none());
        run_round(mk(1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'h0, 1'b0), none());
        check("host_rd_deadbeef", ref_mem[4], 32'hDEAD_BEEF);

        run_round(mk(1'b0, 1'b1, 4'hF, BASE + 32'h10, 32'hFFFF_FFFF, 1'b0), none());
        run_round(none(), mk(1'b1, 1'b1, 4'b0011, 32'd4, 32'h1122_3344, 1'b0));
        run_round(none(), mk(1'b1, 1'b0, 4'hF, 32'd4, 32'h0, 1'b0));
        check("sram_word4", sram[4], 32'hFFFF_3344);

        run_round(mk(1'b0, 1'b0, 4'hF, 32'h2000_0000, 32'h0, 1'b0), none());
        run_round(mk(1'b0, 1'b1, 4'hF, 32'h2000_0040, 32'hBAD0_BAD0, 1'b0), none());

        run_round(mk(1'b0, 1'b1, 4'hF, BASE + 32'h20, 32'hCAFE_F00D, 1'b1), none());
        run_round(mk(1'b0, 1'b0, 4'hF, BASE + 32'h20, 32'h0, 1'b0), none());

        for (int i = 0; i < 300; i++) begin
            op_t h, c;
            h = ($urandom_range(0, 3) != 0) ? rand_host() : none();
            c = ($urandom_range(0, 3) != 0 || !h.valid) ? rand_core() : none();
            run_round(h, c);
        end

        reset_mid_core_read(8'd4);
        run_round(mk(1'b0, 1'b0, 4'hF, BASE + 32'h10, 32'h0, 1'b0),
                  mk(1'b1, 1'b0, 4'hF, 32'd4, 32'h0, 1'b0));
        for (int i = 0; i < 20; i++) run_round(rand_host(), rand_core());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
